// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a registered 4:1 mux path with one-cycle grant latency.
// Define MUX4_ARB_HOLD_LIMIT_EN to cap each grant at HOLD_CYCLES when others are waiting.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       y,
  output logic       y_vld
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       y_q, y_d;
  logic       y_vld_q, y_vld_d;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  // First asserted request found when scanning base, base+1, ... modulo 4.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] win;
    logic [1:0] idx;
    win = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  logic [3:0] others;
  logic [1:0] owner_nxt;
  logic       keep;
  logic [1:0] win;
  logic       y_mux;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    others    = req & ~gnt_q;
    owner_nxt = sel_q + 2'd1;
    keep      = 1'b0;
    win       = 2'd0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          win     = pick_winner(req, ptr_q);
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          cnt_d   = 8'd1;
`endif
        end else begin
          gnt_d = 4'b0000;
        end
      end
      GRANT: begin
        keep = req[sel_q];
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        // An exhausted owner yields only when someone else is actually waiting.
        if (keep && cnt_q >= 8'(HOLD_CYCLES) && others != 4'b0000) keep = 1'b0;
`endif
        if (keep) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          if (cnt_q < 8'(HOLD_CYCLES)) cnt_d = cnt_q + 8'd1;
`endif
        end else if (others != 4'b0000) begin
          win   = pick_winner(others, owner_nxt);
          gnt_d = 4'b0001 << win;
          sel_d = win;
          ptr_d = owner_nxt;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          cnt_d = 8'd1;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_nxt;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    y_mux = 1'b0;
    case (sel_q)
      2'd0:    y_mux = i0;
      2'd1:    y_mux = i1;
      2'd2:    y_mux = i2;
      default: y_mux = i3;
    endcase
    y_vld_d = (gnt_q != 4'b0000);
    y_d     = y_vld_d ? y_mux : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      y_q     <= 1'b0;
      y_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign y     = y_q;
  assign y_vld = y_vld_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; expectations follow MUX4_ARB_HOLD_LIMIT_EN
// when it is defined for the build.
module tb_mux4_rr_arbiter;

  localparam int unsigned HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       i0 = 1'b0, i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
  logic [3:0] gnt;
  logic       s1, s0, y, y_vld;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .s1(s1), .s0(s0), .y(y), .y_vld(y_vld)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] eg, input logic [1:0] es,
                            input logic ey, input logic ev);
    checkOutput({tag, " gnt"}, {4'b0, gnt}, {4'b0, eg});
    checkOutput({tag, " sel"}, {6'b0, s1, s0}, {6'b0, es});
    checkOutput({tag, " y"}, {7'b0, y}, {7'b0, ey});
    checkOutput({tag, " y_vld"}, {7'b0, y_vld}, {7'b0, ev});
  endtask

  // Drive req, then sample 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  // Called 1 unit after a rising edge; returns at the falling edge with reset released.
  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #2;
    checkState(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] eg;
    @(posedge clk);
    #1;
    pulseReset("reset");

    // Single requester, data follows one cycle later.
    i1 = 1'b1;
    applyStimulus(4'b0010); checkState("a1", 4'b0010, 2'd1, 1'b0, 1'b0);
    applyStimulus(4'b0010); checkState("a2", 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(4'b0000); checkState("a3", 4'b0000, 2'd1, 1'b1, 1'b1);
    applyStimulus(4'b0000); checkState("a4", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Full rotation with owners dropping after each grant; y tracks i of previous owner.
    pulseReset("reset_b");
    i0 = 1'b0; i1 = 1'b1; i2 = 1'b1; i3 = 1'b1;
    applyStimulus(4'b1111); checkState("b1", 4'b0001, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1110); checkState("b2", 4'b0010, 2'd1, 1'b0, 1'b1);
    applyStimulus(4'b1101); checkState("b3", 4'b0100, 2'd2, 1'b1, 1'b1);
    applyStimulus(4'b1011); checkState("b4", 4'b1000, 2'd3, 1'b1, 1'b1);
    applyStimulus(4'b0111); checkState("b5", 4'b0001, 2'd0, 1'b1, 1'b1);
    applyStimulus(4'b0000); checkState("b6", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b0000); checkState("b7", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 3 releasing: the search wraps to 0 ahead of 1.
    applyStimulus(4'b1000); checkState("c1", 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(4'b0011); checkState("c2", 4'b0001, 2'd0, 1'b1, 1'b1);
    applyStimulus(4'b0000); checkState("c3", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1000); checkState("c4", 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(4'b0001); checkState("c5", 4'b0001, 2'd0, 1'b1, 1'b1);
    applyStimulus(4'b0000); checkState("c6", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b0000); checkState("c7", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Two persistent requesters: hold limit alternates them, otherwise 0 keeps the path.
    pulseReset("reset_d");
    for (int e = 1; e <= 3 * HOLD; e++) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      eg = (((e - 1) / HOLD) % 2 == 1) ? 4'b0100 : 4'b0001;
`else
      eg = 4'b0001;
`endif
      applyStimulus(4'b0101);
      checkOutput($sformatf("d%0d gnt", e), {4'b0, gnt}, {4'b0, eg});
      checkOutput($sformatf("d%0d sel", e), {6'b0, s1, s0}, {6'b0, (eg == 4'b0100) ? 2'd2 : 2'd0});
    end
    applyStimulus(4'b0000); checkOutput("d_idle gnt", {4'b0, gnt}, 8'h00);
    applyStimulus(4'b0000);

    // Lone owner keeps the grant past the limit; a late competitor then wins immediately.
    pulseReset("reset_s");
    for (int e = 1; e <= HOLD + 4; e++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("s%0d gnt", e), {4'b0, gnt}, 8'h01);
    end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    applyStimulus(4'b0101); checkOutput("s_compete gnt", {4'b0, gnt}, 8'h04);
`else
    applyStimulus(4'b0101); checkOutput("s_compete gnt", {4'b0, gnt}, 8'h01);
`endif
    applyStimulus(4'b0000); checkOutput("s_idle gnt", {4'b0, gnt}, 8'h00);
    applyStimulus(4'b0000);

    // Asynchronous reset between edges during an active grant.
    applyStimulus(4'b0100); checkState("e1", 4'b0100, 2'd2, 1'b0, 1'b0);
    applyStimulus(4'b0100); checkState("e2", 4'b0100, 2'd2, 1'b1, 1'b1);
    #2;
    pulseReset("e_midreset");
    applyStimulus(4'b1000); checkState("e3", 4'b1000, 2'd3, 1'b0, 1'b0);
    applyStimulus(4'b0000); checkState("e4", 4'b0000, 2'd3, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
